// File: rtl/sd_to_apc_if.sv
// sd_to_apc_if: srdy/drdy upstream side and APC phase-change downstream side of sd_to_apc
interface sd_to_apc_if #(parameter int width = 32);
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;
  logic             p_ph_send;
  logic             p_ph_ack;
  logic [width-1:0] p_data;
  modport master (output c_srdy, c_data, p_ph_ack, input c_drdy, p_ph_send, p_data);
  modport slave  (input c_srdy, c_data, p_ph_ack, output c_drdy, p_ph_send, p_data);
endinterface

// File: rtl/sd_to_apc.sv
// sd_to_apc: srdy/drdy to async phase-change transmitter with a 2-entry holding buffer
module sd_to_apc #(parameter int width = 32) (
  input logic         clk,
  input logic         reset_n,
  sd_to_apc_if.slave  io
);
  typedef enum logic [1:0] {s_resync, s_idle, s_wait} state_t;
  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [1:0]       settle_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             rptr_q, wptr_q;
  logic [width-1:0] mem_q [2];
  logic             send_q;
  logic [width-1:0] data_q;
  logic             sync_ack, done, push, launch;
  assign sync_ack     = sync_q[1];
  assign done         = sync_ack == send_q;
  assign io.c_drdy    = cnt_q != 2'd2;
  assign io.p_ph_send = send_q;
  assign io.p_data    = data_q;
  assign push         = io.c_srdy & io.c_drdy;
  // settle_q keeps s_resync closed until the synchronizer holds a real sample of the ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      settle_q <= '0;
    end else begin
      sync_q   <= {sync_q[0], io.p_ph_ack};
      settle_q <= {settle_q[0], 1'b1};
    end
  end
  // next state and launch decision
  always_comb begin
    launch  = 1'b0;
    state_d = state_q;
    case (state_q)
      s_resync: state_d = (settle_q[1] && done) ? s_idle : s_resync;
      s_idle: begin
        launch  = cnt_q != 2'd0;
        state_d = launch ? s_wait : s_idle;
      end
      s_wait: begin
        launch  = done && cnt_q != 2'd0;
        state_d = (done && cnt_q == 2'd0) ? s_idle : s_wait;
      end
      default: state_d = s_resync;
    endcase
    cnt_d = cnt_q + 2'(push) - 2'(launch);
  end
  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= s_resync;
    else state_q <= state_d;
  end
  // holding buffer and launched word; reset drops everything buffered or in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      send_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wptr_q] <= io.c_data;
        wptr_q        <= ~wptr_q;
      end
      if (launch) begin
        data_q <= mem_q[rptr_q];
        send_q <= ~send_q;
        rptr_q <= ~rptr_q;
      end
    end
  end
endmodule
